user_obi_sram_rsp: RTL

OBI subordinate memory responder. It terminates the OBI manager port of user-domain accelerators, acting as the SRAM end of that link. It owns a register-array word memory and accepts read and write requests with byte enables. It returns responses in order after a fixed wait latency, echoing the request ID. Out-of-range accesses get an error response, and a bounded response queue applies back-pressure to the grant.

---
 rtl/user_obi_sram_rsp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/user_obi_sram_rsp.sv
// OBI subordinate SRAM responder: register-array memory with fixed-latency,
// in-order responses and a credit-limited response queue that throttles grant.
module user_obi_sram_rsp #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned NUM_WORDS   = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RSP_DEPTH   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sbr_obi_req_i,
    input  logic [ADDR_WIDTH-1:0]   sbr_obi_addr_i,
    input  logic                    sbr_obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] sbr_obi_be_i,
    input  logic [DATA_WIDTH-1:0]   sbr_obi_wdata_i,
    input  logic [ID_WIDTH-1:0]     sbr_obi_id_i,
    output logic                    sbr_obi_gnt_o,
    input  logic                    sbr_obi_rready_i,
    output logic                    sbr_obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   sbr_obi_rdata_o,
    output logic [ID_WIDTH-1:0]     sbr_obi_rid_o,
    output logic                    sbr_obi_err_o,
    output logic                    busy_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned ENT_W = DATA_WIDTH + ID_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [ENT_W-1:0]      fifo_q [RSP_DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             gnt;
    logic             push;
    logic             pop;
    logic             rvalid;
    logic [ENT_W-1:0] new_ent;
    logic [ENT_W-1:0] push_ent;
    logic [ENT_W-1:0] head_ent;
    logic [1:0]       unused_addr_lsb;

    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             busy_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_addr_lsb = sbr_obi_addr_i[1:0];
    assign word_idx        = sbr_obi_addr_i[IDX_W+1:2];
    assign in_range        = 64'(sbr_obi_addr_i[ADDR_WIDTH-1:2]) < 64'(NUM_WORDS);

    // Credit check uses only registered state, so rready never reaches gnt.
    assign gnt           = sbr_obi_req_i && (outst_q < CNT_W'(RSP_DEPTH));
    assign sbr_obi_gnt_o = gnt;

    // Read data sampled in the grant cycle; writes and errors answer with zero.
    assign new_ent = {(!sbr_obi_we_i && in_range) ? mem_q[word_idx] : {DATA_WIDTH{1'b0}},
                      sbr_obi_id_i, !in_range};

    always_ff @(posedge clk_i) begin
        if (gnt && sbr_obi_we_i && in_range) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (sbr_obi_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= sbr_obi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // The FIFO write is the final latency stage, so only WAIT_CYCLES-1 shift stages precede it.
    if (WAIT_CYCLES > 1) begin : g_pipe
        localparam int unsigned STAGES = WAIT_CYCLES - 1;
        logic [STAGES-1:0] vld_q;
        logic [ENT_W-1:0]  ent_q [STAGES];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= gnt;
                for (int unsigned s = 1; s < STAGES; s++) begin
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            ent_q[0] <= new_ent;
            for (int unsigned s = 1; s < STAGES; s++) begin
                ent_q[s] <= ent_q[s-1];
            end
        end

        assign push     = vld_q[STAGES-1];
        assign push_ent = ent_q[STAGES-1];
    end else begin : g_nopipe
        assign push     = gnt;
        assign push_ent = new_ent;
    end

    assign rvalid   = (fcnt_q != '0);
    assign pop      = rvalid && sbr_obi_rready_i;
    assign head_ent = fifo_q[rd_ptr_q];

    always_comb begin
        outst_d  = outst_q + CNT_W'(gnt) - CNT_W'(pop);
        fcnt_d   = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q  <= '0;
            fcnt_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            outst_q  <= outst_d;
            fcnt_q   <= fcnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            busy_q   <= (outst_d != '0);
        end
    end

    // When full, the popped slot is the one being refilled; the head is read before the edge.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
    end

    assign sbr_obi_rvalid_o = rvalid;
    assign sbr_obi_rdata_o  = rvalid ? head_ent[ENT_W-1 -: DATA_WIDTH] : '0;
    assign sbr_obi_rid_o    = rvalid ? head_ent[ID_WIDTH:1] : '0;
    assign sbr_obi_err_o    = rvalid && head_ent[0];
    assign busy_o           = busy_q;

endmodule
